// File: rtl/dac_spi_serializer_pkg.sv
// Shared definitions for the DAC SPI serializer: FSM state encoding, frame size
// and the helper that assembles a frame word from a sample.
package dac_spi_serializer_pkg;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_e;

    function automatic logic [FRAME_BITS-1:0] makeFrame(input logic [3:0] cmd,
                                                        input logic [7:0] sample);
        return {cmd, sample, 4'b0000};
    endfunction

endpackage

// File: rtl/dac_spi_serializer_spi_clk_divider.sv
// Half-period timer for the SPI engine: while running, emits a one-cycle tick
// every CLK_DIV system clocks; held at zero while stopped.
module spi_clk_divider #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic tick_o
);

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

    logic [7:0] divCnt_q;
    logic [7:0] divCnt_d;

    assign tick_o = run_i && (divCnt_q == DivLast);

    always_comb begin
        divCnt_d = divCnt_q;
        if (!run_i || tick_o) begin
            divCnt_d = '0;
        end else begin
            divCnt_d = divCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_serializer.sv
// Serialises each new 8-bit generator sample to an SPI DAC as a 16-bit mode-0
// frame, and flags samples that were overwritten before they could be sent.
module dac_spi_serializer
    import dac_spi_serializer_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [3:0]  CMD_BITS = 4'b0011
) (
    input  logic       caravel_wb_clk_i,
    input  logic       caravel_wb_rst_ni,
    input  logic       enable_i,
    input  logic [7:0] dac_i,
    input  logic       ovr_clr_i,
    output logic       spi_cs_n_o,
    output logic       spi_sclk_o,
    output logic       spi_sdo_o,
    output logic       busy_o,
    output logic       ovr_o
);

    state_e                state_q, state_d;
    logic                  csN_q, csN_d;
    logic                  sclk_q, sclk_d;
    logic                  sdo_q, sdo_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [4:0]            bitCnt_q, bitCnt_d;
    logic [7:0]            lastSent_q, lastSent_d;
    logic                  forceSend_q, forceSend_d;
    logic                  enPrev_q;
    logic [7:0]            dacPrev_q;
    logic [1:0]            chgCnt_q, chgCnt_d;
    logic                  ovr_q, ovr_d;

    logic                  busy;
    logic                  tick;
    logic                  launch;
    logic                  dacChanged;
    logic [FRAME_BITS-1:0] frameWord;

    assign busy       = (state_q != IDLE);
    assign launch     = (state_q == IDLE) && enable_i && (forceSend_q || (dac_i != lastSent_q));
    assign dacChanged = (dac_i != dacPrev_q);
    assign frameWord  = makeFrame(CMD_BITS, dac_i);

    spi_clk_divider #(
        .CLK_DIV(CLK_DIV)
    ) uDiv (
        .clk_i  (caravel_wb_clk_i),
        .rst_ni (caravel_wb_rst_ni),
        .run_i  (busy),
        .tick_o (tick)
    );

    always_comb begin
        state_d    = state_q;
        csN_d      = csN_q;
        sclk_d     = sclk_q;
        sdo_d      = sdo_q;
        shift_d    = shift_q;
        bitCnt_d   = bitCnt_q;
        lastSent_d = lastSent_q;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    shift_d    = frameWord;
                    lastSent_d = dac_i;
                    csN_d      = 1'b0;
                    sclk_d     = 1'b0;
                    sdo_d      = frameWord[FRAME_BITS-1];
                    bitCnt_d   = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                // Falling SCLK edge: advance to the next bit, or close the frame after the last one.
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d   = 1'b0;
                        shift_d  = {shift_q[FRAME_BITS-2:0], 1'b0};
                        sdo_d    = shift_q[FRAME_BITS-2];
                        bitCnt_d = bitCnt_q + 5'd1;
                        if (bitCnt_q == 5'(FRAME_BITS - 1)) begin
                            csN_d   = 1'b1;
                            sdo_d   = 1'b0;
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A newly raised enable forces one frame even if the sample did not change.
    always_comb begin
        forceSend_d = forceSend_q;
        chgCnt_d    = chgCnt_q;
        ovr_d       = ovr_q;
        if (launch) begin
            forceSend_d = 1'b0;
        end else if (enable_i && !enPrev_q) begin
            forceSend_d = 1'b1;
        end
        if (launch) begin
            chgCnt_d = '0;
        end else if (busy && dacChanged && (chgCnt_q != 2'd2)) begin
            chgCnt_d = chgCnt_q + 2'd1;
        end
        if (busy && dacChanged && (chgCnt_q == 2'd1)) begin
            ovr_d = 1'b1;
        end else if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_ni) begin
        if (!caravel_wb_rst_ni) begin
            state_q     <= IDLE;
            csN_q       <= 1'b1;
            sclk_q      <= 1'b0;
            sdo_q       <= 1'b0;
            shift_q     <= '0;
            bitCnt_q    <= '0;
            lastSent_q  <= '0;
            forceSend_q <= 1'b1;
            enPrev_q    <= 1'b0;
            dacPrev_q   <= '0;
            chgCnt_q    <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            csN_q       <= csN_d;
            sclk_q      <= sclk_d;
            sdo_q       <= sdo_d;
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            lastSent_q  <= lastSent_d;
            forceSend_q <= forceSend_d;
            enPrev_q    <= enable_i;
            dacPrev_q   <= dac_i;
            chgCnt_q    <= chgCnt_d;
            ovr_q       <= ovr_d;
        end
    end

    assign spi_cs_n_o = csN_q;
    assign spi_sclk_o = sclk_q;
    assign spi_sdo_o  = sdo_q;
    assign busy_o     = busy;
    assign ovr_o      = ovr_q;

endmodule
